// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg: shared FSM encoding, access-size codes and address defaults. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    IF_RD = 3'd1,
    D_RD  = 3'd2,
    D_WR  = 3'd3,
    RESP  = 3'd4
  } state_t;

  localparam logic [1:0]  SIZE_B            = 2'd0;
  localparam logic [1:0]  SIZE_H            = 2'd1;
  localparam logic [1:0]  SIZE_W            = 2'd2;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0100_0000;

  // Size code 3 is reserved and always treated as misaligned.
  function automatic logic misaligned(input logic [1:0] off, input logic [1:0] size);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return off[0];
      SIZE_W:  return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if: fetch, data and memory-side signals of the arbiter. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_size;
  logic        d_unsigned;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;

  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        mem_read_write;
  logic [1:0]  mem_access_size;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, d_unsigned, mem_data_out,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
           mem_address, mem_data_in, mem_read_write, mem_access_size
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, d_unsigned, mem_data_out,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
           mem_address, mem_data_in, mem_read_write, mem_access_size
  );
endinterface

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align: store-lane merge and load-lane extract/extend. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  byte_off,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [31:0] merged,
  output logic [31:0] loaded
);

  logic [4:0]  sh_b;
  logic [4:0]  sh_h;
  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  assign sh_b  = {byte_off, 3'b000};
  assign sh_h  = {byte_off[1], 4'b0000};
  assign sel_b = 8'(rword >> sh_b);
  assign sel_h = 16'(rword >> sh_h);

  always_comb begin
    merged = old_word;
    loaded = rword;
    case (size)
      SIZE_B: begin
        merged = (old_word & ~(32'h0000_00FF << sh_b)) | ({24'b0, wdata[7:0]} << sh_b);
        loaded = is_unsigned ? {24'b0, sel_b} : {{24{sel_b[7]}}, sel_b};
      end
      SIZE_H: begin
        merged = (old_word & ~(32'h0000_FFFF << sh_h)) | ({16'b0, wdata[15:0]} << sh_h);
        loaded = is_unsigned ? {16'b0, sel_h} : {{16{sel_h[15]}}, sel_h};
      end
      default: merged = wdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter: fetch/data arbiter onto one word-wide byte-addressed memory. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_arbiter
  import mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int unsigned MEM_DEPTH = 1048576
) (
  input  logic         clock,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  state_t      state, state_n;
  logic        data_owner;
  logic [31:0] addr_q, wdata_q, cap_q, if_rdata_q, d_rdata_q;
  logic [1:0]  size_q, fair_cnt;
  logic        we_q, uns_q, err_q;
  logic        if_gnt, d_gnt, if_err_in, d_err_in, mem_state;
  logic [31:0] merged, loaded;

  function automatic logic in_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && (off < MEM_DEPTH);
  endfunction

  assign if_err_in = misaligned(bus.if_addr[1:0], SIZE_W) || !in_range(bus.if_addr);
  assign d_err_in  = misaligned(bus.d_addr[1:0], bus.d_size) || !in_range(bus.d_addr);

  mem_lane_align u_align (
    .byte_off   (addr_q[1:0]),
    .size       (size_q),
    .is_unsigned(uns_q),
    .old_word   (cap_q),
    .wdata      (wdata_q),
    .rword      (bus.mem_data_out),
    .merged     (merged),
    .loaded     (loaded)
  );

  // Grants are gated by reset so nothing is accepted while the block is held.
  always_comb begin
    state_n = state;
    if_gnt  = 1'b0;
    d_gnt   = 1'b0;
    case (state)
      IDLE: begin
        if (reset) begin
          if (bus.if_req && (!bus.d_req || fair_cnt == 2'd2)) begin
            if_gnt  = 1'b1;
            state_n = if_err_in ? RESP : IF_RD;
          end else if (bus.d_req) begin
            d_gnt = 1'b1;
            if (d_err_in)                          state_n = RESP;
            else if (bus.d_we && bus.d_size == SIZE_W) state_n = D_WR;
            else                                   state_n = D_RD;
          end
        end
      end
      IF_RD:   state_n = RESP;
      D_RD:    state_n = we_q ? D_WR : RESP;
      D_WR:    state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      data_owner <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      err_q      <= 1'b0;
      cap_q      <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      fair_cnt   <= '0;
    end else begin
      state <= state_n;
      if (if_gnt) begin
        data_owner <= 1'b0;
        addr_q     <= bus.if_addr;
        wdata_q    <= '0;
        size_q     <= SIZE_W;
        we_q       <= 1'b0;
        uns_q      <= 1'b0;
        err_q      <= if_err_in;
        fair_cnt   <= '0;
        if (if_err_in) if_rdata_q <= '0;
      end else if (d_gnt) begin
        data_owner <= 1'b1;
        addr_q     <= bus.d_addr;
        wdata_q    <= bus.d_wdata;
        size_q     <= bus.d_size;
        we_q       <= bus.d_we;
        uns_q      <= bus.d_unsigned;
        err_q      <= d_err_in;
        // Only data grants made while a fetch waits count toward fairness.
        fair_cnt   <= bus.if_req ? fair_cnt + 2'd1 : 2'd0;
        if (d_err_in) d_rdata_q <= '0;
      end
      if (state == IF_RD) if_rdata_q <= bus.mem_data_out;
      if (state == D_RD) begin
        cap_q <= bus.mem_data_out;
        if (!we_q) d_rdata_q <= loaded;
      end
      if (state == D_WR) d_rdata_q <= '0;
    end
  end

  assign mem_state           = (state == IF_RD) || (state == D_RD) || (state == D_WR);
  assign bus.if_gnt          = if_gnt;
  assign bus.d_gnt           = d_gnt;
  assign bus.if_rvalid       = (state == RESP) && !data_owner;
  assign bus.d_rvalid        = (state == RESP) && data_owner;
  assign bus.d_err           = (state == RESP) && data_owner && err_q;
  assign bus.if_rdata        = if_rdata_q;
  assign bus.d_rdata         = d_rdata_q;
  assign bus.mem_address     = mem_state ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus.mem_access_size = mem_state ? SIZE_W : 2'd0;
  assign bus.mem_read_write  = (state == D_WR);
  assign bus.mem_data_in     = (state == D_WR) ? merged : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter: directed self-checking bench for mem_arbiter. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;
  import mem_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] mem [0:255];
  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_data;
  int          wr_count;
  int          vectors;
  int          errs;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .BASE_ADDR(32'h0100_0000),
    .MEM_DEPTH(1048576)
  ) dut (
    .clock(clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_data_out = mem[bus.mem_address[9:2]];

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_idx] <= pl_data;
    end else if (bus.mem_read_write) begin
      mem[bus.mem_address[9:2]] <= bus.mem_data_in;
      wr_count <= wr_count + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] data);
    pl_idx  = idx;
    pl_data = data;
    pl_en   = 1'b1;
    @(negedge clk);
    pl_en   = 1'b0;
  endtask

  task automatic do_data(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input logic un,
                         output int lat, output logic [31:0] rd, output logic err);
    logic g;
    bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd; bus.d_size = sz; bus.d_unsigned = un;
    bus.d_req = 1'b1;
    lat = -1; rd = 'x; err = 'x; g = 1'b0;
    for (int i = 0; i < 10 && !g; i++) begin
      #1;
      if (bus.d_gnt) g = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    bus.d_req = 1'b0;
    if (g) begin
      for (int n = 1; n < 10; n++) begin
        #1;
        if (bus.d_rvalid) begin
          lat = n; rd = bus.d_rdata; err = bus.d_err;
          break;
        end
        @(negedge clk);
      end
    end
    @(negedge clk);
  endtask

  task automatic do_fetch(input logic [31:0] a, output int lat, output logic [31:0] rd);
    logic g;
    bus.if_addr = a;
    bus.if_req  = 1'b1;
    lat = -1; rd = 'x; g = 1'b0;
    for (int i = 0; i < 10 && !g; i++) begin
      #1;
      if (bus.if_gnt) g = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    bus.if_req = 1'b0;
    if (g) begin
      for (int n = 1; n < 10; n++) begin
        #1;
        if (bus.if_rvalid) begin
          lat = n; rd = bus.if_rdata;
          break;
        end
        @(negedge clk);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int          lat, w0, k, cnt;
    logic [31:0] rd;
    logic        err, g;
    logic [5:0]  seq;

    vectors = 0; errs = 0; wr_count = 0;
    pl_en = 1'b0; pl_idx = '0; pl_data = '0;
    reset = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.d_size = '0; bus.d_unsigned = 1'b0;

    @(negedge clk);
    preload(8'd0,   32'hDEAD_BEEF);
    preload(8'd4,   32'h80FF_7F01);
    preload(8'd255, 32'h1234_5678);

    // Reset state with both requests asserted
    bus.if_req = 1'b1; bus.d_req = 1'b1; bus.if_addr = 32'h0100_0000; bus.d_addr = 32'h0100_0000;
    #1;
    chk("rst_gnts", {30'b0, bus.if_gnt, bus.d_gnt}, 32'h0);
    chk("rst_valids", {29'b0, bus.if_rvalid, bus.d_rvalid, bus.d_err}, 32'h0);
    chk("rst_mem", {bus.mem_address[29:0], bus.mem_read_write, |bus.mem_access_size}, 32'h0);
    @(negedge clk);
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    do_fetch(32'h0100_0000, lat, rd);
    chk("fetch_lat", lat, 2);
    chk("fetch_data", rd, 32'hDEAD_BEEF);

    do_data(1'b0, 32'h0100_0013, 32'h0, SIZE_B, 1'b0, lat, rd, err);
    chk("lb_data", rd, 32'hFFFF_FF80);
    chk("lb_lat", lat, 2);
    chk("lb_err", err, 0);
    do_data(1'b0, 32'h0100_0013, 32'h0, SIZE_B, 1'b1, lat, rd, err);
    chk("lbu_data", rd, 32'h0000_0080);
    do_data(1'b0, 32'h0100_0012, 32'h0, SIZE_H, 1'b0, lat, rd, err);
    chk("lh_data", rd, 32'hFFFF_80FF);
    do_data(1'b0, 32'h0100_0010, 32'h0, SIZE_H, 1'b1, lat, rd, err);
    chk("lhu_lo", rd, 32'h0000_7F01);

    preload(8'd4, 32'h1122_3344);
    w0 = wr_count;
    do_data(1'b1, 32'h0100_0011, 32'h1234_56AA, SIZE_B, 1'b0, lat, rd, err);
    chk("sb_lat", lat, 3);
    chk("sb_writes", wr_count - w0, 1);
    chk("sb_word", mem[4], 32'h1122_AA44);
    chk("sb_rdata", rd, 32'h0);

    w0 = wr_count;
    do_data(1'b1, 32'h0100_0020, 32'hCAFE_F00D, SIZE_W, 1'b0, lat, rd, err);
    chk("sw_lat", lat, 2);
    chk("sw_word", mem[8], 32'hCAFE_F00D);
    do_data(1'b1, 32'h0100_0022, 32'h0000_BEEF, SIZE_H, 1'b0, lat, rd, err);
    chk("sh_word", mem[8], 32'hBEEF_F00D);
    chk("sw_sh_writes", wr_count - w0, 2);

    w0 = wr_count;
    do_data(1'b0, 32'h0100_0002, 32'h0, SIZE_W, 1'b0, lat, rd, err);
    chk("lw_mis_err", err, 1);
    chk("lw_mis_lat", lat, 1);
    do_data(1'b1, 32'h0100_0001, 32'h0000_5555, SIZE_H, 1'b0, lat, rd, err);
    chk("sh_mis_err", err, 1);
    chk("mis_nowrite", wr_count - w0, 0);
    do_data(1'b0, 32'h00FF_FFFC, 32'h0, SIZE_W, 1'b0, lat, rd, err);
    chk("lw_low_err", err, 1);
    do_data(1'b0, 32'h0110_0000, 32'h0, SIZE_W, 1'b0, lat, rd, err);
    chk("lw_high_err", err, 1);
    do_data(1'b0, 32'h0100_0010, 32'h0, 2'd3, 1'b0, lat, rd, err);
    chk("size3_err", err, 1);
    do_data(1'b0, 32'h010F_FFFC, 32'h0, SIZE_W, 1'b0, lat, rd, err);
    chk("lw_top_ok", {err, rd[30:0]}, {1'b0, 31'h1234_5678});
    do_fetch(32'h0100_0002, lat, rd);
    chk("fetch_mis_data", rd, 32'h0);
    chk("fetch_mis_lat", lat, 1);

    // Both requesters held continuously
    bus.if_addr = 32'h0100_0000;
    bus.d_we = 1'b0; bus.d_addr = 32'h0100_0010; bus.d_size = SIZE_W; bus.d_unsigned = 1'b0;
    bus.if_req = 1'b1; bus.d_req = 1'b1;
    seq = '0; k = 0;
    for (int c = 0; c < 60 && k < 6; c++) begin
      #1;
      if (bus.if_gnt) begin seq[k] = 1'b1; k++; end
      else if (bus.d_gnt) begin seq[k] = 1'b0; k++; end
      @(negedge clk);
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    chk("arb_count", k, 6);
    chk("arb_order", {26'b0, seq}, 32'h24);
    repeat (6) @(negedge clk);

    // Reset asserted in the middle of the write cycle
    bus.d_we = 1'b1; bus.d_addr = 32'h0100_0010; bus.d_wdata = 32'h55; bus.d_size = SIZE_B;
    bus.d_req = 1'b1;
    g = 1'b0;
    for (int i = 0; i < 10 && !g; i++) begin
      #1;
      if (bus.d_gnt) g = 1'b1;
      else @(negedge clk);
    end
    chk("rst_wr_gnt", g, 1);
    @(negedge clk);
    bus.d_req = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_wr_pre", bus.mem_read_write, 1);
    reset = 1'b0;
    #1;
    chk("rst_wr_rw", bus.mem_read_write, 0);
    chk("rst_wr_ctl", {27'b0, bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid, bus.d_err}, 32'h0);
    chk("rst_wr_addr", bus.mem_address, 32'h0);
    chk("rst_wr_din", bus.mem_data_in, 32'h0);
    chk("rst_wr_size", bus.mem_access_size, 0);
    chk("rst_wr_rdata", bus.if_rdata | bus.d_rdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bus.d_rvalid || bus.if_rvalid) cnt++;
      @(negedge clk);
    end
    chk("rst_no_resp", cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h01000000, the byte address of memory location 0.
REQ-002 SHALL have parameter MEM_DEPTH, default 1048576, the memory size in bytes.
REQ-003 SHALL have port clock  in  1  the only clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have if_req in 1, if_addr in 32: instruction-fetch request and byte address, always a word access.
REQ-006 SHALL have if_gnt out 1, if_rvalid out 1, if_rdata out 32: fetch accept pulse, response pulse and data.
REQ-007 SHALL have d_req in 1, d_we in 1, d_addr in 32, d_wdata in 32, d_size in 2, d_unsigned in 1: data request; d_size 0=byte, 1=half, 2=word.
REQ-008 SHALL have d_gnt out 1, d_rvalid out 1, d_rdata out 32, d_err out 1: data accept pulse, response pulse, load data and error flag.
REQ-009 SHALL have mem_address out 32, mem_data_in out 32, mem_data_out in 32, mem_read_write out 1, mem_access_size out 2 to the byte-addressed memory; reads are combinational, and writes commit all 4 bytes on the clock edge while mem_read_write=1.

Function
REQ-010 SHALL use FSM states IDLE, IF_RD, D_RD, D_WR, RESP; only one transaction is outstanding at a time.
REQ-011 SHALL, in IDLE only, grant one pending requester: if_gnt or d_gnt pulses for one cycle, and the request fields are registered on that edge.
REQ-012 SHALL give data priority, except that a pending fetch wins after two consecutive data grants made while the fetch was pending; the counter clears on any fetch grant.
REQ-013 SHALL route an IDLE grant as: fetch -> IF_RD; data error -> RESP; word store -> D_WR; load or sub-word store -> D_RD.
REQ-014 SHALL drive mem_address = registered address with bits [1:0] cleared, and mem_access_size = 2 in every memory state.
REQ-015 SHALL capture mem_data_out at the end of IF_RD or D_RD. IF_RD -> RESP. D_RD -> RESP for a load, or D_WR for a store.
REQ-016 SHALL, in D_WR, assert mem_read_write=1 for exactly one cycle, with mem_data_in = captured word with the addressed byte/half lanes replaced by d_wdata[7:0]/[15:0] (full d_wdata for word); D_WR -> RESP.
REQ-017 SHALL select load lanes by addr[1:0], sign-extend unless d_unsigned=1, and present the result on d_rdata.
REQ-018 SHALL flag an error, with no memory access, when: half with addr[0]=1; word with addr[1:0]!=0; d_size=3; or addr outside [BASE_ADDR, BASE_ADDR+MEM_DEPTH-1]. A fetch checks alignment and range the same way; its error forces if_rdata=0.
REQ-019 SHALL, in RESP, pulse the owning requester's rvalid for one cycle (d_err valid with d_rvalid; d_rdata=0 on a store), then -> IDLE; rdata holds until the next response.
REQ-020 SHALL keep mem_read_write=0 in every state other than D_WR.
REQ-021 SHALL give a back-to-back request its grant earliest in the IDLE cycle after RESP, so the transaction period is 3 cycles minimum (word store, fetch, load) and 4 cycles for a sub-word store.

Reset
REQ-022 SHALL, while reset=0, force state IDLE, fairness counter 0, and all outputs 0 (mem_read_write=0, no grants or valids) immediately, regardless of clock.
REQ-023 SHALL abandon any transaction in flight on reset; a D_WR cut by reset is undefined in memory, and no response is issued afterwards.

Structure
REQ-024 SHALL place the state encoding, size codes (SIZE_B=0, SIZE_H=1, SIZE_W=2) and default BASE_ADDR in shared package mem_pkg.
REQ-025 SHALL implement lane merge and extract (REQ-016, REQ-017) in one combinational sub-module, mem_lane_align.

Verification
REQ-026 Fetch at 0x01000000 with word 0xDEADBEEF preloaded -> if_gnt in cycle 0, if_rvalid with if_rdata=0xDEADBEEF in cycle 2.
REQ-027 Word 0x80FF7F01 at 0x01000010. lb at 0x01000013 -> d_rdata=0xFFFFFF80; lbu at the same address -> 0x00000080; lh at 0x01000012 -> 0xFFFF80FF.
REQ-028 sb 0xAA to 0x01000011 over word 0x11223344 -> exactly one write, memory word becomes 0x1122AA44, d_rvalid 3 cycles after d_gnt.
REQ-029 lw at 0x01000002, and sh at 0x01000001 -> d_err=1 with d_rvalid and mem_read_write never asserted; lw at 0x00FFFFFC -> d_err=1.
REQ-030 if_req and d_req both held high continuously -> grant order D, D, IF, D, D, IF.
REQ-031 reset dropped during D_WR -> mem_read_write=0 and all outputs 0 within that same cycle; no d_rvalid after reset releases.
